// File: rtl/rr_switch_arbiter_pkg.sv
`default_nettype none
// Shared constants, FSM state type and one-hot decode helper for the
// round-robin switch arbiter.
package rr_switch_arbiter_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_switch_arbiter_pick.sv
`default_nettype none
// Combinational rotating priority encoder: the first set request strictly
// after last_i (modulo N) wins.
module rr_pick
  import rr_switch_arbiter_pkg::*;
(
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             any_o,
  output logic [IDX_W-1:0] win_idx_o
);

  logic [IDX_W-1:0] w_start;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  always_comb begin
    // Wrap explicitly so the pointer is modulo N rather than modulo 2^IDX_W.
    w_start = (last_i >= IDX_W'(N - 1)) ? '0 : last_i + 1'b1;
    w_dbl   = {req_i, req_i} >> w_start;
    w_rot   = w_dbl[N-1:0];

    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end

    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= (IDX_W + 1)'(N)) begin
      win_idx_o = IDX_W'(w_sum - (IDX_W + 1)'(N));
    end else begin
      win_idx_o = w_sum[IDX_W-1:0];
    end

    any_o = |req_i;
  end

endmodule
`default_nettype wire

// File: rtl/rr_switch_arbiter.sv
`default_nettype none
// Round-robin arbiter for N request lines: holds one grant until done,
// requester withdrawal or hold timeout, then rotates priority past the winner.
module rr_switch_arbiter
  import rr_switch_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             timeout_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             timeout_q, timeout_d;

  logic             w_any;
  logic [IDX_W-1:0] w_win;
  logic             w_hold_ok;
  logic             w_expire;

  rr_pick u_pick (
    .req_i     (req_i),
    .last_i    (last_q),
    .any_o     (w_any),
    .win_idx_o (w_win)
  );

  assign w_hold_ok = |(req_i & gnt_q);
  assign w_expire  = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          gnt_d   = {{(N - 1){1'b0}}, 1'b1} << w_win;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done_i || !w_hold_ok || w_expire) begin
          gnt_d     = '0;
          last_d    = idx_q;
          state_d   = IDLE;
          // Only a pure expiry is reported; done and withdrawal take precedence.
          timeout_d = !done_i && w_hold_ok;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= IDX_W'(N - 1);
      gnt_q     <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      idx_q     <= onehot_to_idx(gnt_d);
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = (state_q == BUSY);
  assign timeout_o   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_switch_arbiter.sv
`default_nettype none
// Self-checking bench for rr_switch_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_rr_switch_arbiter;

  localparam int NREQ = 8;
  localparam int TMO  = 4;

  logic            clk  = 1'b0;
  logic            rst  = 1'b1;
  logic [NREQ-1:0] req  = '0;
  logic            done = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [3:0]      gnt_idx;
  logic            gnt_valid;
  logic            timeout;
  logic [13:0]     obs;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_busy = 1'b0;
  int m_w    = 0;
  int m_cnt  = 0;
  int m_last = NREQ - 1;
  bit m_to   = 1'b0;

  // Observed outputs packed as {gnt, gnt_idx, gnt_valid, timeout}
  assign obs = {gnt, gnt_idx, gnt_valid, timeout};

  always #5 clk = ~clk;

  rr_switch_arbiter #(
    .TIMEOUT (TMO),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .done_i      (done),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout)
  );

  // Advance the model on the current inputs, then move one clock edge.
  task automatic step();
    int  c;
    bit  found;
    if (rst) begin
      m_busy = 1'b0; m_cnt = 0; m_last = NREQ - 1; m_to = 1'b0;
    end else if (!m_busy) begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (!found && req[c]) begin
          found = 1'b1; m_busy = 1'b1; m_w = c; m_cnt = 0;
        end
      end
    end else begin
      m_to = 1'b0;
      if (done || !req[m_w]) begin
        m_busy = 1'b0; m_last = m_w;
      end else if (m_cnt == TMO - 1) begin
        m_busy = 1'b0; m_last = m_w; m_to = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] model_obs();
    logic [7:0] g;
    g = m_busy ? (8'h1 << m_w) : 8'h0;
    return {g, m_busy ? 4'(m_w) : 4'h0, m_busy, m_to};
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (obs !== 14'h0) begin
      errors++; $display("FAIL reset_state: obs=%h expected=%h", obs, 14'h0);
    end
  endtask

  task automatic test_single();
    req = 8'b0000_1000;
    step();
    checks++;
    if (obs !== {8'h08, 4'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_grant: obs=%h expected=%h", obs, {8'h08, 4'd3, 1'b1, 1'b0});
    end
    done = 1'b1;
    step();
    done = 1'b0; req = '0;
    checks++;
    if (obs !== 14'h0) begin
      errors++; $display("FAIL single_release: obs=%h expected=%h", obs, 14'h0);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (obs !== 14'h0) begin
      errors++; $display("FAIL done_in_idle: obs=%h expected=%h", obs, 14'h0);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] eg;
    do_reset();
    req = 8'hFF;
    step();
    for (int k = 0; k <= 8; k++) begin
      eg = 8'h1 << (k % 8);
      checks++;
      if (obs !== {eg, 4'(k % 8), 1'b1, 1'b0}) begin
        errors++; $display("FAIL fair_grant%0d: obs=%h expected=%h", k, obs, {eg, 4'(k % 8), 1'b1, 1'b0});
      end
      step();
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      checks++;
      if (obs !== 14'h0) begin
        errors++; $display("FAIL fair_release%0d: obs=%h expected=%h", k, obs, 14'h0);
      end
      step();
    end
    req = '0; done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'b0100_0000;
    step();
    done = 1'b1;
    step();
    done = 1'b0; req = 8'b0100_0001;
    step();
    checks++;
    if (obs !== {8'h01, 4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wrap_to_0: obs=%h expected=%h", obs, {8'h01, 4'd0, 1'b1, 1'b0});
    end
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    checks++;
    if (obs !== {8'h40, 4'd6, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wrap_to_6: obs=%h expected=%h", obs, {8'h40, 4'd6, 1'b1, 1'b0});
    end
    req = '0;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'b0010_0000;
    step();
    for (int i = 0; i < TMO; i++) begin
      checks++;
      if (obs !== {8'h20, 4'd5, 1'b1, 1'b0}) begin
        errors++; $display("FAIL timeout_hold%0d: obs=%h expected=%h", i, obs, {8'h20, 4'd5, 1'b1, 1'b0});
      end
      step();
    end
    checks++;
    if (obs !== {8'h00, 4'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL timeout_pulse: obs=%h expected=%h", obs, {8'h00, 4'd0, 1'b0, 1'b1});
    end
    step();
    checks++;
    if (obs !== {8'h20, 4'd5, 1'b1, 1'b0}) begin
      errors++; $display("FAIL timeout_regrant: obs=%h expected=%h", obs, {8'h20, 4'd5, 1'b1, 1'b0});
    end
    req = '0;
    step();
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 8'b0000_1100;
    step();
    step();
    req = 8'b0000_1000;
    step();
    checks++;
    if (obs !== 14'h0) begin
      errors++; $display("FAIL withdraw_release: obs=%h expected=%h", obs, 14'h0);
    end
    req = 8'b0000_1001;
    step();
    step();
    step();
    checks++;
    if (obs !== {8'h08, 4'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL no_preempt: obs=%h expected=%h", obs, {8'h08, 4'd3, 1'b1, 1'b0});
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_collision();
    do_reset();
    req = 8'b0010_0000;
    step();
    step();
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (obs !== 14'h0) begin
      errors++; $display("FAIL done_vs_timeout: obs=%h expected=%h", obs, 14'h0);
    end
    step();
    done = 1'b1; req = '0;
    step();
    done = 1'b0;
    checks++;
    if (obs !== 14'h0) begin
      errors++; $display("FAIL done_and_drop: obs=%h expected=%h", obs, 14'h0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'b0001_0000;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (obs !== 14'h0) begin
      errors++; $display("FAIL reset_mid_grant: obs=%h expected=%h", obs, 14'h0);
    end
    rst = 1'b0; req = 8'h30;
    step();
    checks++;
    if (obs !== {8'h10, 4'd4, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_pointer: obs=%h expected=%h", obs, {8'h10, 4'd4, 1'b1, 1'b0});
    end
    req = '0;
    step();
  endtask

  task automatic test_random();
    logic [13:0] e;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) req = 8'($urandom_range(0, 255));
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      step();
      e = model_obs();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL random_cycle%0d: obs=%h expected=%h", i, obs, e);
      end
      checks++;
      if (!$onehot0(gnt) || (gnt_valid !== (|gnt))) begin
        errors++; $display("FAIL random_invariant%0d: gnt=%h valid=%b expected one-hot with valid=|gnt", i, gnt, gnt_valid);
      end
    end
    rst = 1'b0; done = 1'b0; req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_withdraw();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_switch_arbiter.md
Name: rr_switch_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between 8 switch-style request lines.
- Grants one requester at a time, presents the winner as a one-hot grant and a 4-bit binary index, and holds the grant until the resource signals done, the requester drops, or a timeout expires.
- Replaces fixed lowest-bit-wins selection wherever several inputs contend for the same datapath, so that no requester is starved.

Parameters:
- N, 8, number of requesters.
- IDX_W, 4, width of the binary grant index (index values 0..N-1, MSB spare).
- TIMEOUT, 255, maximum grant-hold cycles before forced release; must be >= 1.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request lines; bit i is requester i, level-sensitive.
- done  input  1  single-cycle pulse from the resource: current transaction finished.
- gnt  output  N  one-hot grant, registered.
- gnt_idx  output  IDX_W  binary index of the granted requester; 0 when no grant is active.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  single-cycle pulse when a grant is force-released.

Behaviour:
- Reset (synchronous; rst sampled high on an edge):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, state=IDLE, hold counter=0.
  - Round-robin pointer last=N-1, so the first search starts at requester 0.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE; outputs stay at their reset values.
  - If req!=0, select winner w = first set bit searching last+1, last+2, ... modulo N (wrap N-1 -> 0).
  - Next edge: gnt=1<<w, gnt_idx=w, gnt_valid=1, counter=0, state=BUSY.
  - Latency: req rises on edge t, grant visible after edge t+1.
- BUSY: counter increments by 1 each cycle (no wrap, since it is bounded by TIMEOUT). Release conditions are checked in this priority order:
  1. done=1: release normally; timeout stays 0.
  2. req[w]=0 (requester withdrew): release; timeout stays 0.
  3. counter==TIMEOUT-1 with no done: release and pulse timeout=1 for one cycle.
- On any release edge: gnt=0, gnt_idx=0, gnt_valid=0, last=w, state=IDLE.
- Minimum one IDLE cycle between grants, so a new grant appears 2 edges after the release condition.
- Boundary rules:
  - done in IDLE is ignored.
  - done and the timeout condition in the same cycle: done wins, no timeout pulse.
  - done and req[w] drop in the same cycle: normal release.
  - Requests on other lines during BUSY do not preempt the current grant.
  - Single requester asserted continuously: it is re-granted after each release (pointer wrap returns to it).
  - rst during BUSY: grant drops on that edge, pointer returns to N-1, and no timeout pulse is issued.
  - Invariants: gnt is always 0 or one-hot; gnt_valid == |gnt.
- Width rules:
  - gnt_idx is zero-extended from ceil(log2 N) bits.
  - Pointer arithmetic is modulo N, not modulo 2^IDX_W.

Decomposition:
- Shared package holds:
  - constants N, IDX_W;
  - the state enum (IDLE=1'b0, BUSY=1'b1);
  - a function converting one-hot to binary index.
- Natural sub-module rr_pick: purely combinational rotating priority encoder.
  - Inputs: req[N-1:0], last[IDX_W-1:0].
  - Outputs: any, win_idx[IDX_W-1:0].
  - Implemented as rotate, then lowest-set-bit, then un-rotate.
  - The top level holds the FSM, the counter, the pointer and the output registers.

Test Plan:
- Reset and single request:
  - rst high 2 cycles, then release -> all outputs 0.
  - req=8'b0000_1000 -> next edge gnt=8'b0000_1000, gnt_idx=4'd3, gnt_valid=1.
- Fairness: req=8'hFF held, done pulsed 3 cycles after each grant -> gnt_idx sequence 0,1,2,3,4,5,6,7,0; gnt always one-hot.
- Wrap from pointer: after serving idx 6, req=8'b0100_0001 -> next grant idx 0 (not 6); after a further done -> idx 6.
- Timeout (TIMEOUT=4): req=8'b0010_0000, done never asserted -> gnt held exactly 4 cycles, then timeout=1 for one cycle and gnt=0; re-granted idx 5 one IDLE cycle later.
- Withdrawal and collision:
  - req[2] drops mid-grant -> released next edge, timeout=0.
  - done coincident with the counter reaching TIMEOUT-1 -> timeout stays 0.
- Reset mid-grant: rst asserted while granting idx 4 -> outputs 0 on that edge; after release with req=8'h30, first grant is idx 4 (pointer reset to 7).
